tour_commit_ctrl: RTL and testbench

TOUR_COMMIT_CTRL -- requirements
Module: tour_commit_ctrl

---
 rtl/graph_pkg.sv | 14 +
 rtl/tour_perm_check.sv | 43 ++++
 rtl/tour_commit_ctrl.sv | 96 +++++++++
 tb/tb_tour_commit_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/graph_pkg.sv
// Shared graph geometry and tour-commit FSM encoding used by the controller, VGAGraph and its bench.
package graph_pkg;

  localparam int N_NODES = 64;
  localparam int COORD_W = 8;
  localparam int IDX_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_PEND = 2'd2
  } state_t;

endpackage

// File: rtl/tour_perm_check.sv
// Tour permutation checker: tracks write position and seen mask, flags length/duplicate errors combinationally.
// No added latency; restart treats the current entry as position 0 with an empty seen mask.
module tour_perm_check
  import graph_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             xfer,
  input  logic             restart,
  input  logic [IDX_W-1:0] data,
  input  logic             last,
  output logic [IDX_W-1:0] wr_pos,
  output logic             done,
  output logic             error
);

  logic [IDX_W-1:0]   pos;
  logic [N_NODES-1:0] seen;
  logic [N_NODES-1:0] seen_eff;
  logic               dup;
  logic               at_end;

  always_comb begin
    wr_pos   = restart ? '0 : pos;
    seen_eff = restart ? '0 : seen;
    dup      = seen_eff[data];
    at_end   = (wr_pos == IDX_W'(N_NODES - 1));
    // last must coincide exactly with the final position, and no node may repeat
    error    = xfer & (dup | (last != at_end));
    done     = xfer & at_end & last & ~dup;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos  <= '0;
      seen <= '0;
    end else if (xfer) begin
      pos  <= wr_pos + 1'b1;
      seen <= seen_eff | (N_NODES'(1) << data);
    end
  end

endmodule

// File: rtl/tour_commit_ctrl.sv
// Double-buffers point coordinates and a checked tour, committing shadow to display arrays on vblank.
// Commit visible one edge after vblank; tour_ready drops while a complete tour waits for vblank.
module tour_commit_ctrl
  import graph_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   vblank,
  input  logic                                   pt_we,
  input  logic [IDX_W-1:0]                       pt_idx,
  input  logic [COORD_W-1:0]                     pt_x,
  input  logic [COORD_W-1:0]                     pt_y,
  input  logic                                   tour_valid,
  output logic                                   tour_ready,
  input  logic [IDX_W-1:0]                       tour_data,
  input  logic                                   tour_last,
  output logic [N_NODES-1:0][COORD_W-1:0]        xs,
  output logic [N_NODES-1:0][COORD_W-1:0]        ys,
  output logic [N_NODES-1:0][IDX_W-1:0]          path,
  output logic [15:0]                            commit_count,
  output logic                                   busy,
  output logic                                   err,
  input  logic                                   err_clr
);

  state_t                              state;
  logic [N_NODES-1:0][COORD_W-1:0]     sxs;
  logic [N_NODES-1:0][COORD_W-1:0]     sys;
  logic [N_NODES-1:0][IDX_W-1:0]       spath;
  logic                                xfer;
  logic [IDX_W-1:0]                    wr_pos;
  logic                                chk_done;
  logic                                chk_err;

  assign tour_ready = (state != ST_PEND);
  assign busy       = (state != ST_IDLE);
  assign xfer       = tour_valid & tour_ready;

  tour_perm_check u_check (
    .clk     (clk),
    .rst     (rst),
    .xfer    (xfer),
    .restart (state == ST_IDLE),
    .data    (tour_data),
    .last    (tour_last),
    .wr_pos  (wr_pos),
    .done    (chk_done),
    .error   (chk_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      err          <= 1'b0;
      commit_count <= '0;
      for (int i = 0; i < N_NODES; i++) begin
        xs[i]    <= '0;
        ys[i]    <= '0;
        sxs[i]   <= '0;
        sys[i]   <= '0;
        path[i]  <= IDX_W'(i);
        spath[i] <= IDX_W'(i);
      end
    end else begin
      if (pt_we) begin
        sxs[pt_idx] <= pt_x;
        sys[pt_idx] <= pt_y;
      end
      if (xfer) spath[wr_pos] <= tour_data;

      // a new error on the same edge as err_clr keeps err set
      if (chk_err)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;

      case (state)
        ST_IDLE, ST_RECV: begin
          if (chk_err)       state <= ST_IDLE;
          else if (chk_done) state <= ST_PEND;
          else if (xfer)     state <= ST_RECV;
        end
        ST_PEND: begin
          // copies read pre-edge shadow values, so a same-edge pt_we waits for the next commit
          if (vblank) begin
            xs    <= sxs;
            ys    <= sys;
            path  <= spath;
            if (commit_count != 16'hFFFF) commit_count <= commit_count + 16'd1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tour_commit_ctrl.sv
// Directed bench for tour_commit_ctrl: reset, commit, duplicate/length errors, vblank collisions, reset in PEND.
module tb_tour_commit_ctrl;
  import graph_pkg::*;

  logic                             clk = 1'b0;
  logic                             rst;
  logic                             vblank;
  logic                             pt_we;
  logic [IDX_W-1:0]                 pt_idx;
  logic [COORD_W-1:0]               pt_x;
  logic [COORD_W-1:0]               pt_y;
  logic                             tour_valid;
  logic                             tour_ready;
  logic [IDX_W-1:0]                 tour_data;
  logic                             tour_last;
  logic [N_NODES-1:0][COORD_W-1:0]  xs;
  logic [N_NODES-1:0][COORD_W-1:0]  ys;
  logic [N_NODES-1:0][IDX_W-1:0]    path;
  logic [15:0]                      commit_count;
  logic                             busy;
  logic                             err;
  logic                             err_clr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tour_commit_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .vblank       (vblank),
    .pt_we        (pt_we),
    .pt_idx       (pt_idx),
    .pt_x         (pt_x),
    .pt_y         (pt_y),
    .tour_valid   (tour_valid),
    .tour_ready   (tour_ready),
    .tour_data    (tour_data),
    .tour_last    (tour_last),
    .xs           (xs),
    .ys           (ys),
    .path         (path),
    .commit_count (commit_count),
    .busy         (busy),
    .err          (err),
    .err_clr      (err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int path_non_identity();
    int n = 0;
    for (int i = 0; i < N_NODES; i++) if (path[i] !== IDX_W'(i)) n++;
    return n;
  endfunction

  function automatic int path_non_reverse();
    int n = 0;
    for (int i = 0; i < N_NODES; i++) if (path[i] !== IDX_W'(63 - i)) n++;
    return n;
  endfunction

  function automatic int coord_nonzero();
    int n = 0;
    for (int i = 0; i < N_NODES; i++) if (xs[i] !== '0 || ys[i] !== '0) n++;
    return n;
  endfunction

  // Streams n back-to-back entries; ovr_k/vb_k/clr_k select one entry for data override, vblank, err_clr.
  task automatic stream(input int n, input bit rev, input int last_at, input int ovr_k,
                        input int ovr_d, input int vb_k, input int clr_k);
    for (int k = 0; k < n; k++) begin
      tour_valid = 1'b1;
      tour_data  = rev ? IDX_W'(63 - k) : IDX_W'(k);
      if (k == ovr_k) tour_data = IDX_W'(ovr_d);
      tour_last  = (k == last_at);
      vblank     = (k == vb_k);
      err_clr    = (k == clr_k);
      tick();
    end
    tour_valid = 1'b0;
    tour_last  = 1'b0;
    vblank     = 1'b0;
    err_clr    = 1'b0;
  endtask

  task automatic pulse_vblank();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vblank = 1'b0; pt_we = 1'b0; pt_idx = '0; pt_x = '0; pt_y = '0;
    tour_valid = 1'b0; tour_data = '0; tour_last = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_path_identity", path_non_identity(), 0);
    chk("rst_coords_zero", coord_nonzero(), 0);
    chk("rst_commit_count", commit_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tour_ready, 1);
    chk("rst_err", err, 0);

    // Duplicate node 7: entry 3 forced to 7, reverse order reaches 7 again at entry 56
    stream(57, 1'b1, -1, 3, 7, -1, -1);
    chk("dup_err", err, 1);
    chk("dup_busy", busy, 0);
    chk("dup_path_identity", path_non_identity(), 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("dup_err_clr", err, 0);

    // tour_last on the 10th entry, err_clr on the same edge: set must win
    stream(10, 1'b1, 9, -1, 0, -1, 9);
    chk("short_err_set_wins", err, 1);
    chk("short_busy", busy, 0);
    pulse_vblank();
    chk("short_no_commit_path", path_non_identity(), 0);
    chk("short_no_commit_count", commit_count, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("short_err_clr", err, 0);

    // Load coordinates into the shadow
    for (int i = 0; i < N_NODES; i++) begin
      pt_we = 1'b1; pt_idx = IDX_W'(i);
      pt_x = COORD_W'((i * 32) % 256);
      pt_y = COORD_W'((i * 27) % 256);
      tick();
    end
    pt_we = 1'b0;
    chk("load_display_untouched", coord_nonzero(), 0);

    // Reverse tour; vblank during RECV must be ignored
    stream(64, 1'b1, 63, -1, 0, 20, -1);
    chk("main_busy", busy, 1);
    chk("main_ready_pend", tour_ready, 0);
    chk("main_err", err, 0);
    tick(); tick();
    chk("main_path_unchanged", path_non_identity(), 0);
    chk("main_xs5_unchanged", xs[5], 0);
    // pt_we on the commit edge lands in the shadow only
    vblank = 1'b1; pt_we = 1'b1; pt_idx = 6'd5; pt_x = 8'hAA; pt_y = 8'hBB;
    tick();
    vblank = 1'b0; pt_we = 1'b0;
    chk("main_path0", path[0], 63);
    chk("main_path_reverse", path_non_reverse(), 0);
    chk("main_xs5", xs[5], 160);
    chk("main_ys5", ys[5], 135);
    chk("main_commit_count", commit_count, 1);
    chk("main_busy_after", busy, 0);

    // Completing transfer coincides with vblank: enter PEND only
    stream(64, 1'b0, 63, -1, 0, 63, -1);
    chk("coinc_busy", busy, 1);
    chk("coinc_no_commit_path0", path[0], 63);
    chk("coinc_no_commit_count", commit_count, 1);
    tick();
    pulse_vblank();
    chk("coinc_commit_path", path_non_identity(), 0);
    chk("coinc_commit_count", commit_count, 2);
    chk("coinc_xs5_late_write", xs[5], 8'hAA);
    chk("coinc_ys5_late_write", ys[5], 8'hBB);

    // Reset while in PEND abandons the tour
    stream(64, 1'b1, 63, -1, 0, -1, -1);
    chk("rstpend_busy", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    chk("rstpend_path_identity", path_non_identity(), 0);
    chk("rstpend_commit_count", commit_count, 0);
    chk("rstpend_ready", tour_ready, 1);
    chk("rstpend_busy", busy, 0);
    chk("rstpend_coords_zero", coord_nonzero(), 0);
    pulse_vblank();
    chk("rstpend_no_late_commit", path_non_identity(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
